hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core; sits beside the forwarding logic in the ID/EX boundary.
- Generates PC/IF_ID write enables and IF_ID/ID_EX flushes.
- Covers three cases: load-use stalls, taken-branch flushes, and multi-cycle stalls while the multiply/divide unit (MDU) is busy.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MDU_LATENCY, 8, cycles the pipeline is held after an MDU op is accepted (legal range 2..15)
CNT_W, 16, width of the stall-cycle performance counter

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-high reset
ID_EX_MemRead  input  1  instruction in EX is a load
ID_EX_RegisterRt  input  5  destination of the load in EX
IF_ID_RegisterRs  input  5  source Rs of the instruction in ID
IF_ID_RegisterRt  input  5  source Rt of the instruction in ID
Branch_Taken  input  1  branch/jump resolved taken in EX this cycle
MDU_Start  input  1  instruction in ID is a mult/div and requests issue
PC_Write  output  1  PC load enable
IF_ID_Write  output  1  IF/ID register load enable
IF_ID_Flush  output  1  zero the IF/ID register at the next edge
ID_EX_Flush  output  1  load a bubble (all control zero) into ID/EX at the next edge
MDU_Busy  output  1  MDU hold in progress
Stall_Cycles  output  CNT_W  count of cycles with PC_Write=0

Behaviour:
- Reset (async, while reset=1):
  - state=RUN, down-counter=0, Stall_Cycles=0.
  - Outputs: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Flush=1, MDU_Busy=0.
- Out of reset, outputs are combinational from state plus inputs. State and counters update on the rising clk edge.
- load_use = ID_EX_MemRead & (ID_EX_RegisterRt!=0) & (ID_EX_RegisterRt==IF_ID_RegisterRs | ID_EX_RegisterRt==IF_ID_RegisterRt).
- RUN, first match wins:
  1. Branch_Taken=1:
     - PC_Write=1, IF_ID_Write=1, IF_ID_Flush=1, ID_EX_Flush=1.
     - load_use and MDU_Start are ignored; the MDU_Start is in a squashed slot and is never accepted.
  2. load_use=1:
     - PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=1 (one bubble).
     - MDU_Start is not accepted this cycle. It remains asserted next cycle because ID is held.
  3. MDU_Start=1:
     - Normal enables this cycle (the MDU instruction advances to EX).
     - At the edge: state->MDU_WAIT, counter<=MDU_LATENCY-1.
  4. Otherwise: PC_Write=1, IF_ID_Write=1, both flushes=0.
- MDU_WAIT:
  - Outputs: PC_Write=0, IF_ID_Write=0, IF_ID_Flush=0, ID_EX_Flush=1, MDU_Busy=1.
  - Branch_Taken, load_use and MDU_Start are ignored.
  - Counter decrements each edge. At an edge where counter==0, state->RUN.
  - Total hold is exactly MDU_LATENCY cycles.
- Stall_Cycles:
  - Increments at each edge where PC_Write=0 and reset=0.
  - Saturates at 2^CNT_W-1 and never wraps.
- Reset asserted mid-MDU_WAIT: immediate return to RUN with counter cleared; no pending hold survives.
- Back-to-back MDU ops: the second MDU_Start is seen in RUN on the cycle after MDU_WAIT exits and starts a new full hold. There is no RUN gap other than that one issue cycle.

Test Plan:
- Reset release: reset=1 mid-cycle, then 0 with all inputs 0 -> during reset PC_Write=0, both flushes=1, Stall_Cycles=0; first cycle after release PC_Write=1, IF_ID_Write=1, flushes=0.
- Load-use: ID_EX_MemRead=1, ID_EX_RegisterRt=5, IF_ID_RegisterRs=5 for one cycle -> PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, Stall_Cycles 0->1. Repeat with Rt=0 -> no stall.
- Branch priority: Branch_Taken=1 together with load_use=1 and MDU_Start=1 -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, state stays RUN, MDU_Busy never asserts.
- MDU hold, MDU_LATENCY=8: MDU_Start=1 for one cycle in RUN -> MDU_Busy=1 and PC_Write=0 for exactly 8 cycles, then RUN; Stall_Cycles=8.
- Reset mid-hold: assert reset in the 4th MDU_WAIT cycle -> MDU_Busy drops asynchronously; after release a single MDU_Start gives a full 8-cycle hold again.
- Saturation, CNT_W=4: hold MDU_Start/latency so 20 stall cycles occur -> Stall_Cycles stops at 15.

Source files
------------

// File: rtl/hazard_stall_controller.sv
// Pipeline hazard/stall sequencer for the 5-stage core: load-use bubbles, taken-branch
// squashes and multi-cycle holds while the multiply/divide unit is busy.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; branch flush and load-use bubble decided here
// MDU_WAIT | pipeline frozen for MDU_LATENCY cycles after an MDU issue
module hazard_stall_controller #(
   parameter int MDU_LATENCY = 8,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ID_EX_MemRead,
   input  logic [4:0]       ID_EX_RegisterRt,
   input  logic [4:0]       IF_ID_RegisterRs,
   input  logic [4:0]       IF_ID_RegisterRt,
   input  logic             Branch_Taken,
   input  logic             MDU_Start,
   output logic             PC_Write,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Flush,
   output logic             MDU_Busy,
   output logic [CNT_W-1:0] Stall_Cycles
);

   typedef enum logic {RUN = 1'b0, MDU_WAIT = 1'b1} state_t;

   localparam logic [3:0]       HOLD_INIT = 4'(MDU_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   state_t     state;
   logic [3:0] holdCnt;
   logic       loadUse;
   logic       acceptMdu;

   assign loadUse = ID_EX_MemRead && (ID_EX_RegisterRt != 5'd0) &&
                    ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                     (ID_EX_RegisterRt == IF_ID_RegisterRt));

   // Reset is folded in here so the outputs go safe the moment reset rises.
   always_comb begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
      MDU_Busy    = 1'b0;
      acceptMdu   = 1'b0;
      if (reset) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (state == MDU_WAIT) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
         MDU_Busy    = 1'b1;
      end else if (Branch_Taken) begin
         IF_ID_Flush = 1'b1;
         ID_EX_Flush = 1'b1;
      end else if (loadUse) begin
         PC_Write    = 1'b0;
         IF_ID_Write = 1'b0;
         ID_EX_Flush = 1'b1;
      end else if (MDU_Start) begin
         acceptMdu   = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= RUN;
         holdCnt      <= 4'd0;
         Stall_Cycles <= '0;
      end else begin
         case (state)
            RUN: begin
               if (acceptMdu) begin
                  state   <= MDU_WAIT;
                  holdCnt <= HOLD_INIT;
               end
            end
            MDU_WAIT: begin
               if (holdCnt == 4'd0) begin
                  state <= RUN;
               end else begin
                  holdCnt <= holdCnt - 4'd1;
               end
            end
            default: begin
               state   <= RUN;
               holdCnt <= 4'd0;
            end
         endcase
         if (!PC_Write && (Stall_Cycles != CNT_MAX)) begin
            Stall_Cycles <= Stall_Cycles + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: table-driven RUN-state vectors plus
// hand sequences for MDU holds, reset mid-hold and counter saturation (second instance, CNT_W=4).
module tb_hazard_stall_controller;

   logic        clk;
   logic        reset;
   logic        memRead;
   logic [4:0]  exRt;
   logic [4:0]  idRs;
   logic [4:0]  idRt;
   logic        branchTaken;
   logic        mduStart;

   logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, mduBusy;
   logic [15:0] stallCycles;
   logic        sPcWrite, sIfIdWrite, sIfIdFlush, sIdExFlush, sMduBusy;
   logic [3:0]  sStallCycles;

   hazard_stall_controller #(.MDU_LATENCY(8), .CNT_W(16)) dut (
      .clk(clk), .reset(reset),
      .ID_EX_MemRead(memRead), .ID_EX_RegisterRt(exRt),
      .IF_ID_RegisterRs(idRs), .IF_ID_RegisterRt(idRt),
      .Branch_Taken(branchTaken), .MDU_Start(mduStart),
      .PC_Write(pcWrite), .IF_ID_Write(ifIdWrite),
      .IF_ID_Flush(ifIdFlush), .ID_EX_Flush(idExFlush),
      .MDU_Busy(mduBusy), .Stall_Cycles(stallCycles)
   );

   hazard_stall_controller #(.MDU_LATENCY(8), .CNT_W(4)) dutSat (
      .clk(clk), .reset(reset),
      .ID_EX_MemRead(memRead), .ID_EX_RegisterRt(exRt),
      .IF_ID_RegisterRs(idRs), .IF_ID_RegisterRt(idRt),
      .Branch_Taken(branchTaken), .MDU_Start(mduStart),
      .PC_Write(sPcWrite), .IF_ID_Write(sIfIdWrite),
      .IF_ID_Flush(sIfIdFlush), .ID_EX_Flush(sIdExFlush),
      .MDU_Busy(sMduBusy), .Stall_Cycles(sStallCycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flag order: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, MDU_Busy}
   localparam logic [4:0] F_RUN  = 5'b11000;
   localparam logic [4:0] F_BR   = 5'b11110;
   localparam logic [4:0] F_LU   = 5'b00010;
   localparam logic [4:0] F_WAIT = 5'b00011;
   localparam logic [4:0] F_RST  = 5'b00110;

   typedef struct {
      logic       memRead;
      logic [4:0] exRt;
      logic [4:0] idRs;
      logic [4:0] idRt;
      logic       br;
      logic       mdu;
      logic [4:0] flags;
   } vec_t;

   typedef struct {
      logic [4:0]  flags;
      logic [15:0] stalls;
      logic [3:0]  satStalls;
      int          tag;
   } exp_t;

   exp_t sbQ[$];
   int   errors = 0;
   int   checks = 0;
   int   stallModel = 0;
   int   stepTag = 0;
   vec_t vecs[11];

   function automatic logic [3:0] satModel();
      return (stallModel > 15) ? 4'd15 : 4'(stallModel);
   endfunction

   task automatic check(input string nm, input int tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h required %h", nm, tag, got, exp);
      end
   endtask

   task automatic checkNow(input string nm, input logic [4:0] flags, input int stalls);
      check({nm, "_flags"}, stepTag, {11'd0, pcWrite, ifIdWrite, ifIdFlush, idExFlush, mduBusy}, {11'd0, flags});
      check({nm, "_stalls"}, stepTag, stallCycles, 16'(stalls));
      check({nm, "_satflags"}, stepTag, {11'd0, sPcWrite, sIfIdWrite, sIfIdFlush, sIdExFlush, sMduBusy}, {11'd0, flags});
      check({nm, "_satstalls"}, stepTag, {12'd0, sStallCycles}, {12'd0, satModel()});
   endtask

   // Called at posedge+1: drive, score at negedge, advance model across the next edge.
   task automatic drive(input logic mr, input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2,
                        input logic br, input logic mdu, input logic [4:0] expFlags);
      exp_t e;
      exp_t got;
      memRead = mr; exRt = rt; idRs = rs; idRt = rt2; branchTaken = br; mduStart = mdu;
      e.flags = expFlags;
      e.stalls = 16'(stallModel);
      e.satStalls = satModel();
      e.tag = stepTag;
      sbQ.push_back(e);
      @(negedge clk);
      got = sbQ.pop_front();
      check("flags", got.tag, {11'd0, pcWrite, ifIdWrite, ifIdFlush, idExFlush, mduBusy}, {11'd0, got.flags});
      check("stalls", got.tag, stallCycles, got.stalls);
      check("sat_flags", got.tag, {11'd0, sPcWrite, sIfIdWrite, sIfIdFlush, sIdExFlush, sMduBusy}, {11'd0, got.flags});
      check("sat_stalls", got.tag, {12'd0, sStallCycles}, {12'd0, got.satStalls});
      if (!got.flags[4]) stallModel++;
      stepTag++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic [4:0] expFlags);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, expFlags);
   endtask

   task automatic mduHold();
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, F_RUN);
      for (int i = 0; i < 8; i++) begin
         // Hazard inputs are driven during the hold and must be ignored.
         drive(i == 5, 5'd3, 5'd3, 5'd0, i == 2, i == 6, F_WAIT);
      end
   endtask

   // Called at posedge+1: assert reset mid-cycle, release after the next negedge.
   task automatic pulseReset();
      reset = 1'b1;
      #1;
      stallModel = 0;
      checkNow("reset_async", F_RST, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout required completion");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, F_RUN};
      vecs[1]  = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, F_LU};
      vecs[2]  = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, F_RUN};
      vecs[3]  = '{1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, F_LU};
      vecs[4]  = '{1'b0, 5'd7, 5'd7, 5'd7, 1'b0, 1'b0, F_RUN};
      vecs[5]  = '{1'b1, 5'd9, 5'd2, 5'd3, 1'b0, 1'b0, F_RUN};
      vecs[6]  = '{1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, F_BR};
      vecs[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, F_RUN};
      vecs[8]  = '{1'b1, 5'd6, 5'd1, 5'd6, 1'b0, 1'b1, F_LU};
      vecs[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, F_BR};
      vecs[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, F_RUN};

      reset = 1'b1;
      memRead = 1'b0; exRt = '0; idRs = '0; idRt = '0; branchTaken = 1'b0; mduStart = 1'b0;
      #3;
      checkNow("reset_hold", F_RST, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      foreach (vecs[i]) begin
         drive(vecs[i].memRead, vecs[i].exRt, vecs[i].idRs, vecs[i].idRt,
               vecs[i].br, vecs[i].mdu, vecs[i].flags);
      end

      mduHold();
      idle(F_RUN);

      // Reset lands in the 4th hold cycle.
      drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, F_RUN);
      for (int i = 0; i < 3; i++) idle(F_WAIT);
      checkNow("hold4_busy", F_WAIT, stallModel);
      pulseReset();
      idle(F_RUN);
      mduHold();
      idle(F_RUN);
      check("after_rehold", stepTag, stallCycles, 16'd8);

      // Two back-to-back holds plus four load-use bubbles: 20 stall cycles.
      pulseReset();
      mduHold();
      mduHold();
      for (int i = 0; i < 4; i++) drive(1'b1, 5'd12, 5'd12, 5'd0, 1'b0, 1'b0, F_LU);
      idle(F_RUN);
      check("total_stalls", stepTag, stallCycles, 16'd20);
      check("saturated", stepTag, {12'd0, sStallCycles}, 16'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
